// File: rtl/rng_pkg.sv
// rng_pkg: shared types, constants and the replica LFSR step for the stream checker.
package rng_pkg;

    typedef enum logic [1:0] {IDLE, SEED, WAIT, CHECK} chk_state_t;
    typedef enum logic {FIBO = 1'b0, GALO = 1'b1} lfsr_mode_t;

    localparam logic [7:0] FIBO_TAPS = 8'b1001_0100;  // feedback = s7 ^ s4 ^ s2
    localparam logic [7:0] GALO_TAPS = 8'b0111_0000;  // bits toggled by the shifted-out MSB
    localparam int         BYTE_BITS = 8;

    // One replica step: returns {expected_bit, next_state}.
    function automatic logic [8:0] lfsr_step(input lfsr_mode_t mode, input logic [7:0] s);
        logic       fb;
        logic [7:0] nxt;
        if (mode == GALO) begin
            fb  = s[7];
            nxt = {s[6:0], fb} ^ (fb ? GALO_TAPS : 8'h00);
        end else begin
            fb  = ^(s & FIBO_TAPS);
            nxt = {s[6:0], fb};
        end
        return {fb, nxt};
    endfunction

endpackage

// File: rtl/rng_stream_checker_if.sv
// rng_stream_checker_if: byte stream handshake between generator side and checker.
interface rng_stream_checker_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;

    modport master (output in_valid, output in_byte, input in_ready);
    modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational inverse AES S-box, same bit order as the forward table.
// Only compiled when INV_SBOX_EN is defined; otherwise the checker takes the raw byte.
`ifdef INV_SBOX_EN
module aes_inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
        8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
        8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
        8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
        8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
        8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
        8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
        8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
        8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
        8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
        8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
        8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
        8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
        8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
        8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
        8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
    };

    assign out_byte = INV_SBOX[in_byte];
endmodule
`endif

// File: rtl/rng_stream_checker.sv
// rng_stream_checker: receive-side checker for the LFSR/S-box random byte stream.
// A byte is taken over valid/ready, optionally un-mapped through the inverse S-box,
// then shifted out MSB-first against a local replica LFSR (Fibonacci or Galois).
// Build option INV_SBOX_EN: defined -> inverse S-box in the capture path (checks the
// full generator output); undefined -> raw byte captured (checks the pre-S-box tap).
module rng_stream_checker
    import rng_pkg::*;
#(
    parameter int CNT_W = 16   // >= 4 so one byte's worth of errors fits the carry bit
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [7:0]           seed,
    input  logic                 sel,
    input  logic                 start,
    input  logic                 stop,
    rng_stream_checker_if.slave  in_if,
    output logic                 busy,
    output logic                 byte_done,
    output logic                 byte_ok,
    output logic [CNT_W-1:0]     bit_errs,
    output logic [CNT_W-1:0]     byte_cnt
);

    localparam int         SUM_W    = CNT_W + 1;
    localparam logic [2:0] LAST_IDX = 3'(BYTE_BITS - 1);

    chk_state_t       state_q;
    lfsr_mode_t       mode_q;
    logic [7:0]       rep_q;
    logic [7:0]       sreg_q;
    logic [2:0]       idx_q;
    logic [3:0]       tally_q;
    logic             busy_q;
    logic             ready_q;
    logic             done_q;
    logic             ok_q;
    logic [CNT_W-1:0] bit_errs_q;
    logic [CNT_W-1:0] byte_cnt_q;

    logic [7:0]       cap_d;
    logic [8:0]       step_d;
    logic             mism_d;
    logic [3:0]       tally_d;
    logic             last_d;
    logic [SUM_W-1:0] err_sum_d;
    logic [CNT_W-1:0] bit_errs_d;
    logic [CNT_W-1:0] byte_cnt_d;

`ifdef INV_SBOX_EN
    aes_inv_sbox u_inv_sbox (
        .in_byte  (in_if.in_byte),
        .out_byte (cap_d)
    );
`else
    assign cap_d = in_if.in_byte;
`endif

    // Per-bit compare and saturating counter updates for the current CHECK cycle.
    assign step_d     = lfsr_step(mode_q, rep_q);
    assign mism_d     = sreg_q[7] ^ step_d[8];
    assign tally_d    = tally_q + {3'b000, mism_d};
    assign last_d     = (idx_q == LAST_IDX);
    assign err_sum_d  = {1'b0, bit_errs_q} + SUM_W'(tally_d);
    assign bit_errs_d = err_sum_d[CNT_W] ? '1 : err_sum_d[CNT_W-1:0];
    assign byte_cnt_d = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + CNT_W'(1);

    // Control FSM and datapath; every output is taken straight from a flop.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= IDLE;
            mode_q     <= FIBO;
            rep_q      <= 8'h00;
            sreg_q     <= 8'h00;
            idx_q      <= 3'd0;
            tally_q    <= 4'd0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            bit_errs_q <= '0;
            byte_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q <= SEED;
                        busy_q  <= 1'b1;
                    end
                end
                SEED: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rep_q      <= seed;
                        mode_q     <= lfsr_mode_t'(sel);
                        bit_errs_q <= '0;
                        byte_cnt_q <= '0;
                        ok_q       <= 1'b0;
                        ready_q    <= 1'b1;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                    end else if (in_if.in_valid) begin
                        sreg_q  <= cap_d;
                        idx_q   <= 3'd0;
                        tally_q <= 4'd0;
                        ready_q <= 1'b0;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    sreg_q  <= {sreg_q[6:0], 1'b0};
                    rep_q   <= step_d[7:0];
                    tally_q <= tally_d;
                    idx_q   <= idx_q + 3'd1;
                    // byte_done is already showing in the last cycle, so the result is
                    // committed even if stop arrives then; earlier stops discard the byte.
                    if (last_d) begin
                        ok_q       <= (tally_d == 4'd0);
                        bit_errs_q <= bit_errs_d;
                        byte_cnt_q <= byte_cnt_d;
                    end
                    if (stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_d) begin
                        state_q <= WAIT;
                        ready_q <= 1'b1;
                    end else if (idx_q == LAST_IDX - 3'd1) begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_if.in_ready = ready_q;
    assign busy           = busy_q;
    assign byte_done      = done_q;
    assign byte_ok        = ok_q;
    assign bit_errs       = bit_errs_q;
    assign byte_cnt       = byte_cnt_q;

endmodule

// File: tb/tb_rng_stream_checker.sv
// tb_rng_stream_checker: directed bench for rng_stream_checker. Two instances share
// the stimulus: a 16-bit counter build and a 4-bit one for saturation.
module tb_rng_stream_checker;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic        sel = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready, in_ready4;
    logic        busy, byte_done, byte_ok;
    logic [15:0] bit_errs, byte_cnt;
    logic        busy4, done4, ok4;
    logic [3:0]  errs4, cnt4;

    int tests_run = 0;
    int tests_failed = 0;

    // Bytes on the wire whose recovered value is 2D, 52, FD, FF, 00 respectively.
`ifdef INV_SBOX_EN
    localparam logic [7:0] B_MATCH = 8'hD8, B_BAD = 8'h00, B_2ND = 8'h54, B_ONES = 8'h16, B_ZERO = 8'h63;
    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    function automatic logic [7:0] enc(input logic [7:0] x);
        return SBOX[x];
    endfunction
`else
    localparam logic [7:0] B_MATCH = 8'h2D, B_BAD = 8'h52, B_2ND = 8'hFD, B_ONES = 8'hFF, B_ZERO = 8'h00;
    function automatic logic [7:0] enc(input logic [7:0] x);
        return x;
    endfunction
`endif

    // Golden Galois model: 8 steps from state s, returns {next_state, expected_byte}.
    function automatic logic [15:0] galo_byte(input logic [7:0] s);
        logic [7:0] b;
        logic       fb;
        b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            fb = s[7];
            s  = {s[6], s[5] ^ fb, s[4] ^ fb, s[3] ^ fb, s[2:0], fb};
            b  = {b[6:0], fb};
        end
        return {s, b};
    endfunction

    rng_stream_checker_if if16 ();
    rng_stream_checker_if if4 ();
    assign if16.in_valid = in_valid;
    assign if16.in_byte  = in_byte;
    assign if4.in_valid  = in_valid;
    assign if4.in_byte   = in_byte;
    assign in_ready      = if16.in_ready;
    assign in_ready4     = if4.in_ready;

    rng_stream_checker #(.CNT_W(16)) dut (
        .clk(clk), .reset_L(reset_L), .seed(seed), .sel(sel), .start(start), .stop(stop),
        .in_if(if16), .busy(busy), .byte_done(byte_done), .byte_ok(byte_ok),
        .bit_errs(bit_errs), .byte_cnt(byte_cnt)
    );

    rng_stream_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .reset_L(reset_L), .seed(seed), .sel(sel), .start(start), .stop(stop),
        .in_if(if4), .busy(busy4), .byte_done(done4), .byte_ok(ok4),
        .bit_errs(errs4), .byte_cnt(cnt4)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks begin and end at a falling edge.
    task automatic do_seed(input logic [7:0] s, input logic m);
        seed = s; sel = m; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
    endtask

    task automatic go_idle();
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    // Hand one byte over; lat = falling edges from handshake to byte_done (-1 on timeout).
    task automatic send_byte(input logic [7:0] b, output int lat);
        lat = -1;
        in_valid = 1'b1; in_byte = b;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (byte_done) begin lat = i; break; end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2;
        tests_run++; if ({busy, in_ready, byte_done, byte_ok, busy4, in_ready4, done4, ok4} !== 8'h00) begin tests_failed++; $display("FAIL reset_flags: got %b want 00000000", {busy, in_ready, byte_done, byte_ok, busy4, in_ready4, done4, ok4}); end
        tests_run++; if ({bit_errs, byte_cnt, errs4, cnt4} !== 40'h0) begin tests_failed++; $display("FAIL reset_counts: got %h want 0", {bit_errs, byte_cnt, errs4, cnt4}); end
        @(negedge clk); reset_L = 1'b1;
        @(negedge clk); @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_fibo_match();
        int lat;
        do_seed(8'h01, 1'b0);
        tests_run++; if ({busy, in_ready} !== 2'b11) begin tests_failed++; $display("FAIL wait_flags: got %b want 11", {busy, in_ready}); end
        send_byte(B_MATCH, lat);
        tests_run++; if (lat !== 8) begin tests_failed++; $display("FAIL match_latency: got %0d want 8", lat); end
        tests_run++; if ({byte_ok, byte_done, in_ready} !== 3'b101) begin tests_failed++; $display("FAIL match_ok: got %b want 101", {byte_ok, byte_done, in_ready}); end
        tests_run++; if (bit_errs !== 16'd0 || byte_cnt !== 16'd1) begin tests_failed++; $display("FAIL match_cnts: got errs=%0d cnt=%0d want 0 1", bit_errs, byte_cnt); end
    endtask

    task automatic test_fibo_mismatch();
        int lat;
        go_idle();
        do_seed(8'h01, 1'b0);
        tests_run++; if ({byte_ok, byte_cnt} !== 17'h0) begin tests_failed++; $display("FAIL seed_clear: got ok=%b cnt=%0d want 0 0", byte_ok, byte_cnt); end
        start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
        tests_run++; if ({busy, in_ready} !== 2'b11) begin tests_failed++; $display("FAIL start_busy: got %b want 11", {busy, in_ready}); end
        send_byte(B_BAD, lat);
        tests_run++; if (byte_ok !== 1'b0 || bit_errs !== 16'd7 || byte_cnt !== 16'd1) begin tests_failed++; $display("FAIL mismatch: got ok=%b errs=%0d cnt=%0d want 0 7 1", byte_ok, bit_errs, byte_cnt); end
    endtask

    task automatic test_back_to_back();
        int first, second;
        first = -1; second = -1;
        go_idle();
        do_seed(8'h01, 1'b0);
        in_valid = 1'b1; in_byte = B_MATCH;
        @(posedge clk);
        @(negedge clk); in_byte = B_2ND;
        for (int i = 1; i <= 30; i++) begin
            if (byte_done) begin
                if (first < 0) first = i; else if (second < 0) second = i;
            end
            if (second >= 0) break;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++; if (first !== 8 || second !== 17) begin tests_failed++; $display("FAIL b2b_timing: got %0d %0d want 8 17", first, second); end
        tests_run++; if (byte_ok !== 1'b1 || bit_errs !== 16'd0 || byte_cnt !== 16'd2) begin tests_failed++; $display("FAIL b2b_result: got ok=%b errs=%0d cnt=%0d want 1 0 2", byte_ok, bit_errs, byte_cnt); end
    endtask

    task automatic test_galois();
        logic [7:0]  s;
        logic [15:0] g;
        int          lat;
        go_idle();
        do_seed(8'hA5, 1'b1);
        s = 8'hA5;
        tests_run++; if ({bit_errs, byte_cnt} !== 32'h0) begin tests_failed++; $display("FAIL galo_seed: got %h want 0", {bit_errs, byte_cnt}); end
        for (int n = 0; n < 16; n++) begin
            g = galo_byte(s); s = g[15:8];
            send_byte(enc(g[7:0]), lat);
            tests_run++; if (byte_ok !== 1'b1 || lat !== 8) begin tests_failed++; $display("FAIL galo_byte%0d: got ok=%b lat=%0d want 1 8", n, byte_ok, lat); end
        end
        tests_run++; if (byte_cnt !== 16'd16 || bit_errs !== 16'd0) begin tests_failed++; $display("FAIL galo_cnt: got cnt=%0d errs=%0d want 16 0", byte_cnt, bit_errs); end
        g = galo_byte(s);
        send_byte(enc(g[7:0] ^ 8'h10), lat);
        tests_run++; if (byte_ok !== 1'b0 || bit_errs !== 16'd1 || byte_cnt !== 16'd17) begin tests_failed++; $display("FAIL galo_flip: got ok=%b errs=%0d cnt=%0d want 0 1 17", byte_ok, bit_errs, byte_cnt); end
        tests_run++; if (cnt4 !== 4'hF) begin tests_failed++; $display("FAIL cnt_sat: got %h want f", cnt4); end
    endtask

    task automatic test_stop();
        logic seen;
        seen = 1'b0;
        in_valid = 1'b1; in_byte = B_BAD;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        repeat (4) @(negedge clk);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        tests_run++; if ({busy, in_ready} !== 2'b00) begin tests_failed++; $display("FAIL stop_idle: got %b want 00", {busy, in_ready}); end
        repeat (10) begin
            if (byte_done) seen = 1'b1;
            @(negedge clk);
        end
        tests_run++; if (seen !== 1'b0 || byte_cnt !== 16'd17 || bit_errs !== 16'd1) begin tests_failed++; $display("FAIL stop_hold: got done=%b cnt=%0d errs=%0d want 0 17 1", seen, byte_cnt, bit_errs); end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_seed(8'h01, 1'b0);
        send_byte(B_BAD, lat);
        in_valid = 1'b1; in_byte = B_MATCH;
        @(posedge clk);
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_L = 1'b0;
        #1;
        tests_run++; if ({busy, in_ready, byte_done, byte_ok, bit_errs, byte_cnt} !== 36'h0) begin tests_failed++; $display("FAIL reset_mid: got %h want 0", {busy, in_ready, byte_done, byte_ok, bit_errs, byte_cnt}); end
        @(negedge clk); reset_L = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int lat;
        do_seed(8'h00, 1'b0);
        send_byte(B_ONES, lat);
        tests_run++; if (errs4 !== 4'd8 || byte_ok !== 1'b0) begin tests_failed++; $display("FAIL sat_first: got errs4=%0d ok=%b want 8 0", errs4, byte_ok); end
        send_byte(B_ONES, lat);
        tests_run++; if (errs4 !== 4'hF || bit_errs !== 16'd16) begin tests_failed++; $display("FAIL sat_stick: got errs4=%0d errs=%0d want 15 16", errs4, bit_errs); end
        send_byte(B_ZERO, lat);
        tests_run++; if (byte_ok !== 1'b1 || errs4 !== 4'hF || byte_cnt !== 16'd3) begin tests_failed++; $display("FAIL sat_zero: got ok=%b errs4=%0d cnt=%0d want 1 15 3", byte_ok, errs4, byte_cnt); end
    endtask

    initial begin
        test_reset();
        test_fibo_match();
        test_fibo_mismatch();
        test_back_to_back();
        test_galois();
        test_stop();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
